// File: rtl/rf_param.sv
// rf_param: parameterised register file with per-register inc/dec/load/clear and sticky wrap flags.
// Optional macro RF_BYPASS_EN: read ports forward the next-state value of a register being written.
`default_nettype none

module rf_param #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int SATURATE = 0,
  localparam int SW      = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       FunSel,
  input  logic [NREGS-1:0] RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SW-1:0]    OutASel,
  input  logic [SW-1:0]    OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREGS-1:0] Wrap
);

  localparam logic [1:0]       FUN_DEC  = 2'b00;
  localparam logic [1:0]       FUN_INC  = 2'b01;
  localparam logic [1:0]       FUN_LOAD = 2'b10;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam int               NSEL     = 2 ** SW;

  logic [WIDTH-1:0] regs     [NREGS];
  logic [WIDTH-1:0] nxt_regs [NREGS];
  logic [NREGS-1:0] wrap_q;
  logic [NREGS-1:0] nxt_wrap;
  logic [WIDTH-1:0] rd_src   [NSEL];

  // Boundary detection uses the pre-edge value, so a saturated register re-flags on every attempt.
  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      nxt_regs[k] = regs[k];
      nxt_wrap[k] = wrap_q[k];
      if (!RegSel[k]) begin
        case (FunSel)
          FUN_DEC: begin
            if (regs[k] == ZERO) begin
              nxt_wrap[k] = 1'b1;
              nxt_regs[k] = (SATURATE != 0) ? ZERO : ONES;
            end else begin
              nxt_regs[k] = regs[k] - ONE;
            end
          end
          FUN_INC: begin
            if (regs[k] == ONES) begin
              nxt_wrap[k] = 1'b1;
              nxt_regs[k] = (SATURATE != 0) ? ONES : ZERO;
            end else begin
              nxt_regs[k] = regs[k] + ONE;
            end
          end
          FUN_LOAD: nxt_regs[k] = I;
          default: begin
            nxt_regs[k] = ZERO;
            nxt_wrap[k] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= ZERO;
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) regs[k] <= nxt_regs[k];
      wrap_q <= nxt_wrap;
    end
  end

  // Pad the read mux to the full select range so out-of-range indices read as zero.
  generate
    for (genvar g = 0; g < NSEL; g++) begin : g_rd
      if (g < NREGS) begin : g_hit
`ifdef RF_BYPASS_EN
        assign rd_src[g] = nxt_regs[g];
`else
        assign rd_src[g] = regs[g];
`endif
      end else begin : g_miss
        assign rd_src[g] = ZERO;
      end
    end
  endgenerate

  assign OutA = rd_src[OutASel];
  assign OutB = rd_src[OutBSel];
  assign Wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_param.sv
// tb_rf_param: scoreboard bench driving three rf_param configurations from one stimulus stream.
`default_nettype none

module tb_rf_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  fs = 2'b11;
  logic [4:0]  rs = 5'h1F;
  logic [15:0] din = '0;
  logic [2:0]  as = '0;
  logic [2:0]  bs = '0;

  logic [7:0]  oa0, ob0, oa1, ob1;
  logic [15:0] oa2, ob2;
  logic [3:0]  wr0, wr1;
  logic [4:0]  wr2;

  always #5 clk = ~clk;

  rf_param #(.WIDTH(8), .NREGS(4), .SATURATE(0)) u_wrap (
    .Clock(clk), .Reset(rst_n), .FunSel(fs), .RegSel(rs[3:0]), .I(din[7:0]),
    .OutASel(as[1:0]), .OutBSel(bs[1:0]), .OutA(oa0), .OutB(ob0), .Wrap(wr0));
  rf_param #(.WIDTH(8), .NREGS(4), .SATURATE(1)) u_sat (
    .Clock(clk), .Reset(rst_n), .FunSel(fs), .RegSel(rs[3:0]), .I(din[7:0]),
    .OutASel(as[1:0]), .OutBSel(bs[1:0]), .OutA(oa1), .OutB(ob1), .Wrap(wr1));
  rf_param #(.WIDTH(16), .NREGS(5), .SATURATE(0)) u_wide (
    .Clock(clk), .Reset(rst_n), .FunSel(fs), .RegSel(rs), .I(din),
    .OutASel(as), .OutBSel(bs), .OutA(oa2), .OutB(ob2), .Wrap(wr2));

  localparam int unsigned MASK [3] = '{32'h00FF, 32'h00FF, 32'hFFFF};
  localparam int          NR   [3] = '{4, 4, 5};
  localparam bit          SAT  [3] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned SELM [3] = '{3, 3, 7};
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          d;
    int          kind;
    int unsigned val;
  } exp_t;

  exp_t        sbq[$];
  int unsigned mreg  [3][16];
  bit          mwrap [3][16];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned act(input int d, input int kind);
    case (d)
      0: return (kind == 0) ? 32'(oa0) : (kind == 1) ? 32'(ob0) : 32'(wr0);
      1: return (kind == 0) ? 32'(oa1) : (kind == 1) ? 32'(ob1) : 32'(wr1);
      default: return (kind == 0) ? 32'(oa2) : (kind == 1) ? 32'(ob2) : 32'(wr2);
    endcase
  endfunction

  function automatic int unsigned nv(input int d, input int k);
    int unsigned v = mreg[d][k];
    int unsigned m = MASK[d];
    if (rs[k]) return v;
    case (fs)
      2'b00:   return (v == 0) ? (SAT[d] ? 0 : m) : v - 1;
      2'b01:   return (v == m) ? (SAT[d] ? m : 0) : v + 1;
      2'b10:   return 32'(din) & m;
      default: return 0;
    endcase
  endfunction

  function automatic bit nw(input int d, input int k);
    if (rs[k]) return mwrap[d][k];
    case (fs)
      2'b00:   return mwrap[d][k] | (mreg[d][k] == 0);
      2'b01:   return mwrap[d][k] | (mreg[d][k] == MASK[d]);
      2'b10:   return mwrap[d][k];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned rd(input int d, input int unsigned sel);
    int unsigned s = sel & SELM[d];
    return (s < 32'(NR[d])) ? mreg[d][s] : 0;
  endfunction

  task automatic step(input bit r, input logic [1:0] f, input logic [4:0] sel_n,
                      input logic [15:0] data, input logic [2:0] a, input logic [2:0] b);
    int unsigned nx [3][16];
    bit          nwr[3][16];
    exp_t        e;
    @(negedge clk);
    rst_n = r; fs = f; rs = sel_n; din = data; as = a; bs = b;
    #1;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < NR[d]; k++) begin
        nx[d][k]  = r ? nv(d, k) : 0;
        nwr[d][k] = r ? nw(d, k) : 1'b0;
      end
    // Port A of the first instance is also observed before the edge.
    if (r) check("pre_edge_a", act(0, 0), BYP ? (((a & 3) < 4) ? nv(0, a & 3) : 0) : rd(0, a));
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      int unsigned w = 0;
      for (int k = 0; k < NR[d]; k++) begin
        mreg[d][k]  = nx[d][k];
        mwrap[d][k] = nwr[d][k];
        if (nwr[d][k]) w |= (1 << k);
      end
      e.d = d;
      e.tag = $sformatf("d%0d_outa", d); e.kind = 0; e.val = rd(d, a); sbq.push_back(e);
      e.tag = $sformatf("d%0d_outb", d); e.kind = 1; e.val = rd(d, b); sbq.push_back(e);
      e.tag = $sformatf("d%0d_wrap", d); e.kind = 2; e.val = w;        sbq.push_back(e);
    end
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, act(e.d, e.kind), e.val);
    end
  endtask

  initial begin
    // Reset with a load pending, then broadcast load.
    step(1'b0, 2'b10, 5'h00, 16'h00E4, 3'd0, 3'd3);
    check("reset_outa", 32'(oa0), 32'h00);
    step(1'b1, 2'b10, 5'h00, 16'h00E4, 3'd0, 3'd3);
    check("bcast_outb", 32'(ob0), 32'hE4);
    // R1 wraps on increment; load keeps the flag, clear drops it.
    step(1'b1, 2'b10, 5'h1D, 16'h00FF, 3'd1, 3'd1);
    step(1'b1, 2'b01, 5'h1D, 16'h0000, 3'd1, 3'd1);
    check("inc_wrap_val", 32'(oa0), 32'h00);
    check("inc_wrap_flag", 32'(wr0), 32'h2);
    check("inc_sat_val", 32'(oa1), 32'hFF);
    step(1'b1, 2'b10, 5'h1D, 16'h0005, 3'd1, 3'd1);
    check("load_keeps_wrap", 32'(wr0), 32'h2);
    step(1'b1, 2'b11, 5'h1D, 16'h0000, 3'd1, 3'd1);
    check("clear_wrap", 32'(wr0), 32'h0);
    // R2 saturating/wrapping decrement then increment to the top.
    step(1'b1, 2'b10, 5'h1B, 16'h0000, 3'd2, 3'd2);
    step(1'b1, 2'b00, 5'h1B, 16'h0000, 3'd2, 3'd2);
    step(1'b1, 2'b00, 5'h1B, 16'h0000, 3'd2, 3'd2);
    check("sat_dec_floor", 32'(oa1), 32'h00);
    check("sat_dec_flag", 32'(wr1[2]), 32'h1);
    step(1'b1, 2'b10, 5'h1B, 16'h00FE, 3'd2, 3'd2);
    for (int n = 0; n < 3; n++) step(1'b1, 2'b01, 5'h1B, 16'h0000, 3'd2, 3'd2);
    check("sat_inc_ceiling", 32'(ob1), 32'hFF);
    // Nothing selected: clears are ignored.
    for (int n = 0; n < 3; n++) step(1'b1, 2'b11, 5'h1F, 16'h0000, 3'd0, 3'd3);
    // Out-of-range select and the fifth register of the wide instance.
    step(1'b1, 2'b10, 5'h0F, 16'h0820, 3'd6, 3'd4);
    check("oob_read", 32'(oa2), 32'h0);
    check("r4_read", 32'(ob2), 32'h0820);
    step(1'b1, 2'b10, 5'h1E, 16'h006D, 3'd0, 3'd0);
    check("r0_after_edge", 32'(oa0), 32'h6D);
    // Random traffic, including multi-register selections and occasional reset.
    for (int n = 0; n < 40; n++)
      step($urandom_range(0, 15) != 0, 2'($urandom), 5'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom));
    step(1'b0, 2'b10, 5'h00, 16'hFFFF, 3'd1, 3'd4);
    check("final_reset_wrap", 32'(wr2), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every register, of I, of OutA and of OutB; legal range 2..32.
REQ-002 Parameter NREGS, default 4: number of registers; legal range 2..16.
REQ-003 Parameter SATURATE, default 0: 0 selects wrap-around inc/dec; 1 selects saturating inc/dec.
REQ-004 Localparam SW = max(1, clog2(NREGS)): width of the read-select ports.
REQ-005 Clock  input  1  system clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset.
REQ-007 FunSel  input  2  operation: 00 decrement, 01 increment, 10 load I, 11 clear.
REQ-008 RegSel  input  NREGS  per-register enable, active-low; bit k=0 makes register k take the FunSel operation.
REQ-009 I  input  WIDTH  load data.
REQ-010 OutASel  input  SW  read port A register index.
REQ-011 OutBSel  input  SW  read port B register index.
REQ-012 OutA  output  WIDTH  contents of register OutASel.
REQ-013 OutB  output  WIDTH  contents of register OutBSel.
REQ-014 Wrap  output  NREGS  sticky per-register flag: wrap event (SATURATE=0) or saturation event (SATURATE=1).

Function
REQ-015 Every register with RegSel bit 0 SHALL update on the same edge; multiple simultaneous selections are legal and independent.
REQ-016 A register with RegSel bit 1 SHALL hold its value and its Wrap bit.
REQ-017 Load SHALL write I. Clear SHALL write 0 and clear that register's Wrap bit.
REQ-018 Increment SHALL add 1 modulo 2^WIDTH when SATURATE=0, and SHALL hold at 2^WIDTH-1 when SATURATE=1.
REQ-019 Decrement SHALL subtract 1 modulo 2^WIDTH when SATURATE=0, and SHALL hold at 0 when SATURATE=1.
REQ-020 Wrap[k] SHALL set on the edge where an inc/dec on register k starts at the boundary: all-ones for inc, zero for dec.
REQ-021 Wrap[k] SHALL stay set until a clear on register k or reset; load SHALL NOT affect it.
REQ-022 OutA and OutB SHALL be combinational reads of register state; a write SHALL be visible the cycle after its edge.
REQ-023 Read selects at or above NREGS SHALL produce 0 on that port.
REQ-024 Both ports SHALL be able to select the same register at the same time.

Reset
REQ-025 When Reset=0 at a rising edge, all registers SHALL become 0 and Wrap SHALL become 0, regardless of FunSel and RegSel.
REQ-026 Reset SHALL abort any operation presented in the same cycle; no partial update SHALL occur.
REQ-027 After reset release, OutA=OutB=0 until the first write.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: a read port whose selected register is enabled in the current cycle SHALL output that register's next-state value combinationally (load shows I, clear shows 0, inc/dec show the computed result).
REQ-029 Macro RF_BYPASS_EN undefined: read ports SHALL show only stored state, per REQ-022.

Verification
REQ-030 WIDTH=8, NREGS=4: reset; load I=0xE4 with RegSel=0000; next cycle OutASel=0, OutBSel=3 -> OutA=0xE4, OutB=0xE4.
REQ-031 SATURATE=0: load 0xFF into R1, increment R1 -> R1=0x00, Wrap=0010; load 0x05 -> Wrap stays 0010; clear -> Wrap=0000.
REQ-032 SATURATE=1: load 0x00 into R2, decrement twice -> R2=0x00, Wrap[2]=1; load 0xFE, increment 3x -> R2=0xFF.
REQ-033 RegSel=1111 with FunSel=11 for 3 cycles -> all registers unchanged; then Reset=0 with load pending -> all 0, Wrap=0.
REQ-034 NREGS=5, WIDTH=16: OutASel=6 -> OutA=0x0000; load 0x0820 into R4 -> OutBSel=4 gives 0x0820 next cycle.
REQ-035 RF_BYPASS_EN defined: load 0x6D into R0 while OutASel=0 -> OutA=0x6D in the same cycle before the edge; macro undefined -> OutA=0x6D only after the edge.
